// File: rtl/spike_collector.sv
// spike_collector
// Collects spike packets addressed to this node into a 21x21 bitmap. When the
// timestep closes (NUM_ADDERS DONE packets), the bitmap is streamed out one row
// per transfer. Every streamed row is cleared as it leaves. After NUM_TIMESTEPS
// flushes the block parks in FINISHED until reset.
//
// Ports:
//   clk, reset      - single clock, asynchronous active-high reset
//   in_valid/ready  - packet input handshake; in_data carries the packet:
//                     [63:60] dest, [59:56] src, [53:52] type, [9:0] {x, y}
//   out_valid/ready - row output handshake
//   out_row         - row index x of the row being offered
//   out_bits        - bit y set when spike (x, y) fired this timestep
//   out_timestep    - current timestep index
//   out_last        - high with row 20
//   all_done        - high once the final timestep has been flushed
//   drop_count      - saturating count of rejected packets
module spike_collector #(
  parameter int         WIDTH         = 64,
  parameter logic [3:0] MY_ADDRESS    = 4'b1010,
  parameter int         NUM_ADDERS    = 5,
  parameter int         NUM_TIMESTEPS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_row,
  output logic [20:0]      out_bits,
  output logic [3:0]       out_timestep,
  output logic             out_last,
  output logic             all_done,
  output logic [15:0]      drop_count
);

  localparam logic [4:0] LAST_ROW = 5'd20;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    FLUSH    = 2'd1,
    FINISHED = 2'd2
  } stateT;

  stateT       stateReg;
  stateT       stateNext;
  logic [2:0]  doneCnt;
  logic [4:0]  rowPtr;
  logic [3:0]  timestep;
  logic [15:0] dropCnt;
  logic [20:0] bitmap [21];

  // Packet field decode
  logic [3:0] pktDest;
  logic [1:0] pktType;
  logic [4:0] pktX;
  logic [4:0] pktY;
  logic       pktForMe;
  logic       pktIsDone;
  logic       pktInRange;

  assign pktDest    = in_data[63:60];
  assign pktType    = in_data[53:52];
  assign pktX       = in_data[9:5];
  assign pktY       = in_data[4:0];
  assign pktForMe   = (pktDest == MY_ADDRESS) && (pktType == 2'b11);
  assign pktIsDone  = (in_data[9:0] == 10'h3FF);
  assign pktInRange = (pktX <= LAST_ROW) && (pktY <= LAST_ROW);

  // Source and reserved fields are carried but not interpreted here.
  logic unusedBits;
  assign unusedBits = ^in_data;

  // Handshakes derived from the state directly, so the next-state logic never
  // reads back its own outputs.
  logic pktAccept;
  logic rowAccept;
  logic acceptDone;
  logic acceptSpike;
  logic acceptDrop;
  logic lastDone;
  logic lastRow;
  logic [3:0] tsNext;

  assign pktAccept   = in_valid && (stateReg == COLLECT);
  assign rowAccept   = out_ready && (stateReg == FLUSH);
  assign acceptDone  = pktAccept && pktForMe && pktIsDone;
  // DONE uses address 3FF, which would otherwise be out of range; it is
  // recognised first so it never counts as a drop.
  assign acceptSpike = pktAccept && pktForMe && !pktIsDone && pktInRange;
  assign acceptDrop  = pktAccept && !(pktForMe && (pktIsDone || pktInRange));
  assign lastDone    = acceptDone && (doneCnt == 3'(NUM_ADDERS - 1));
  assign lastRow     = rowAccept && (rowPtr == LAST_ROW);
  assign tsNext      = timestep + 4'd1;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg <= COLLECT;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    stateNext = stateReg;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    all_done  = 1'b0;
    case (stateReg)
      COLLECT: begin
        in_ready = 1'b1;
        if (lastDone) begin
          stateNext = FLUSH;
        end
      end
      FLUSH: begin
        out_valid = 1'b1;
        if (lastRow) begin
          stateNext = (tsNext == 4'(NUM_TIMESTEPS)) ? FINISHED : COLLECT;
        end
      end
      FINISHED: begin
        all_done = 1'b1;
      end
      default: begin
        stateNext = COLLECT;
      end
    endcase
  end

  // Spike bitmap: set on accepted spikes, row cleared as it is streamed out.
  // The two never coincide because they live in different states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 21; r++) begin
        bitmap[r] <= '0;
      end
    end else begin
      if (rowAccept) begin
        bitmap[rowPtr] <= '0;
      end
      if (acceptSpike) begin
        bitmap[pktX][pktY] <= 1'b1;
      end
    end
  end

  // Counters and pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      doneCnt  <= '0;
      rowPtr   <= '0;
      timestep <= '0;
      dropCnt  <= '0;
    end else begin
      if (acceptDone) begin
        doneCnt <= lastDone ? 3'd0 : doneCnt + 3'd1;
      end
      if (rowAccept) begin
        if (rowPtr == LAST_ROW) begin
          rowPtr   <= '0;
          timestep <= tsNext;
        end else begin
          rowPtr <= rowPtr + 5'd1;
        end
      end
      if (acceptDrop && (dropCnt != 16'hFFFF)) begin
        dropCnt <= dropCnt + 16'd1;
      end
    end
  end

  // rowPtr rests at 0 outside FLUSH, so out_row needs no gating.
  assign out_row      = rowPtr;
  assign out_bits     = (stateReg == FLUSH) ? bitmap[rowPtr] : 21'd0;
  assign out_last     = (stateReg == FLUSH) && (rowPtr == LAST_ROW);
  assign out_timestep = timestep;
  assign drop_count   = dropCnt;

endmodule
